// File: rtl/cde_ctrl_pkg.sv
// ============================================================================
// Module : cde_ctrl_pkg
// Brief  : Shared encodings for the credential datapath sequencing controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cde_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_BOOT   = 2'd0,
        OP_LOOKUP = 2'd1,
        OP_ENROLL = 2'd2,
        OP_RSVD   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_NOMATCH = 2'd1,
        ST_FULL    = 2'd2,
        ST_ERR     = 2'd3
    } status_e;

    typedef enum logic [4:0] {
        S_IDLE  = 5'd0,
        S_B_RD  = 5'd1,
        S_B_LAT = 5'd2,
        S_B_WR  = 5'd3,
        S_LAT   = 5'd4,
        S_CAM   = 5'd5,
        S_CWAIT = 5'd6,
        S_RD    = 5'd7,
        S_PLAT  = 5'd8,
        S_DEC   = 5'd9,
        S_DWAIT = 5'd10,
        S_ACC   = 5'd11,
        S_KEY   = 5'd12,
        S_ENC   = 5'd13,
        S_EWAIT = 5'd14,
        S_OUT   = 5'd15,
        S_PREG  = 5'd16,
        S_WR    = 5'd17,
        S_RESP  = 5'd18
    } state_e;

    localparam int DP_CAM_START        = 0;
    localparam int DP_START_DEC        = 1;
    localparam int DP_START_ENC        = 2;
    localparam int DP_FLASH_PASS_REG   = 3;
    localparam int DP_FLASH_ACC_REG    = 4;
    localparam int DP_FLASH_OR_ACC_REG = 5;
    localparam int DP_FLASH_OR_ACC_SEL = 6;
    localparam int DP_PASS_ENC_REG     = 7;
    localparam int DP_NEW_OLD_PASS_SEL = 8;
    localparam int DP_PLAIN_REG        = 9;
    localparam int DP_LOCAL_MASTER_REG = 10;
    localparam int DP_LOCAL_MASTER_SEL = 11;
    localparam int DP_OUT_REG          = 12;
    localparam int DP_WRITE_EN         = 13;
    localparam int DP_BOOT_LOOD        = 14;

    localparam int          WAIT_W    = 10;
    localparam logic [9:0]  WDOG_LOAD = 10'd1023;

endpackage

`default_nettype wire

// File: rtl/cde_ctrl_if.sv
// ============================================================================
// Module : cde_ctrl_if
// Brief  : Command request / status response bundle of the cde controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface cde_ctrl_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  cmd_valid;
    logic [1:0]            cmd_op;
    logic                  cmd_ready;
    logic [ADDR_WIDTH:0]   boot_count;
    logic                  resp_valid;
    logic [1:0]            resp_status;

    modport master (
        output cmd_valid, cmd_op, boot_count,
        input  cmd_ready, resp_valid, resp_status
    );

    modport slave (
        input  cmd_valid, cmd_op, boot_count,
        output cmd_ready, resp_valid, resp_status
    );
endinterface

`default_nettype wire

// File: rtl/cde_ctrl_wait.sv
// ============================================================================
// Module : cde_ctrl_wait
// Brief  : Loadable down-counter that saturates at zero; flags zero.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cde_ctrl_wait #(
    parameter int WIDTH = 10
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_val,
    output logic                  zero
);
    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);
endmodule

`default_nettype wire

// File: rtl/cde_ctrl.sv
// ============================================================================
// Module : cde_ctrl
// Brief  : Sequencer for CAM / AES credential datapath (BOOT, LOOKUP, ENROLL).
//          Optional DEC/ENC watchdog enabled by defining CDE_CTRL_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cde_ctrl
    import cde_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int CAM_LAT    = 2
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    cde_ctrl_if.slave                  bus,
    input  wire logic                  match,
    input  wire logic                  dec_done,
    input  wire logic                  ready_encryption,
    output logic [15:0]                dp_ctrl,
    output logic [ADDR_WIDTH-1:0]      write_add,
    output logic                       flash_rd_en,
    output logic                       flash_wr_en,
    output logic [ADDR_WIDTH:0]        entry_cnt
);
    localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_e                  state_q, state_d;
    op_e                     op_q, op_d;
    logic [ADDR_WIDTH:0]     boot_cnt_q, boot_cnt_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic                    clamp_q, clamp_d;
    logic [ADDR_WIDTH:0]     entry_cnt_q, entry_cnt_d;
    logic [15:0]             dp_ctrl_q, dp_ctrl_d;
    logic [ADDR_WIDTH-1:0]   write_add_q, write_add_d;
    logic                    flash_rd_en_q, flash_rd_en_d;
    logic                    flash_wr_en_q, flash_wr_en_d;
    logic                    resp_valid_q, resp_valid_d;
    status_e                 resp_status_q, resp_status_d;
    logic                    cmd_ready_q, cmd_ready_d;
    status_e                 status_d;
    logic                    wait_load;
    logic [WAIT_W-1:0]       wait_val;
    logic                    wait_zero;
    logic [ADDR_WIDTH:0]     idx_next;

    assign idx_next = {1'b0, idx_q} + 1'b1;

    cde_ctrl_wait #(.WIDTH(WAIT_W)) u_wait (
        .clk      (clk),
        .rst      (rst),
        .load     (wait_load),
        .load_val (wait_val),
        .zero     (wait_zero)
    );

    // Next state plus the registered (Moore) outputs belonging to that state.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        boot_cnt_d  = boot_cnt_q;
        idx_d       = idx_q;
        clamp_d     = clamp_q;
        entry_cnt_d = entry_cnt_q;
        status_d    = ST_OK;
        wait_load   = 1'b0;
        wait_val    = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    op_d = op_e'(bus.cmd_op);
                    case (op_e'(bus.cmd_op))
                        OP_BOOT: begin
                            entry_cnt_d = '0;
                            idx_d       = '0;
                            clamp_d     = (bus.boot_count > CAPACITY);
                            boot_cnt_d  = (bus.boot_count > CAPACITY) ? CAPACITY : bus.boot_count;
                            state_d     = (bus.boot_count == '0) ? S_RESP : S_B_RD;
                        end
                        OP_LOOKUP: state_d = S_LAT;
                        OP_ENROLL: begin
                            if (entry_cnt_q == CAPACITY) begin
                                state_d  = S_RESP;
                                status_d = ST_FULL;
                            end else begin
                                state_d = S_LAT;
                            end
                        end
                        default: begin
                            state_d  = S_RESP;
                            status_d = ST_ERR;
                        end
                    endcase
                end
            end
            S_B_RD:  state_d = S_B_LAT;
            S_B_LAT: state_d = S_B_WR;
            S_B_WR: begin
                if (idx_next == boot_cnt_q) begin
                    state_d     = S_RESP;
                    entry_cnt_d = boot_cnt_q;
                    status_d    = clamp_q ? ST_ERR : ST_OK;
                end else begin
                    idx_d   = idx_next[ADDR_WIDTH-1:0];
                    state_d = S_B_RD;
                end
            end
            S_LAT: begin
                state_d   = S_CAM;
                wait_load = 1'b1;
                wait_val  = WAIT_W'(CAM_LAT);
            end
            S_CAM: state_d = S_CWAIT;
            S_CWAIT: begin
                if (wait_zero) begin
                    if (op_q == OP_LOOKUP) begin
                        state_d  = match ? S_RD : S_RESP;
                        status_d = match ? ST_OK : ST_NOMATCH;
                    end else begin
                        state_d  = match ? S_RESP : S_ACC;
                        status_d = match ? ST_ERR : ST_OK;
                    end
                end
            end
            S_RD:   state_d = S_PLAT;
            S_PLAT: begin
                state_d = S_DEC;
`ifdef CDE_CTRL_TIMEOUT_EN
                wait_load = 1'b1;
                wait_val  = WDOG_LOAD;
`endif
            end
            // The start cycle itself never samples the done pulse.
            S_DEC: state_d = S_DWAIT;
            S_DWAIT: begin
                if (dec_done)
                    state_d = S_KEY;
`ifdef CDE_CTRL_TIMEOUT_EN
                else if (wait_zero) begin
                    state_d  = S_RESP;
                    status_d = ST_ERR;
                end
`endif
            end
            S_ACC: state_d = S_KEY;
            S_KEY: begin
                state_d = S_ENC;
`ifdef CDE_CTRL_TIMEOUT_EN
                wait_load = 1'b1;
                wait_val  = WDOG_LOAD;
`endif
            end
            S_ENC: state_d = S_EWAIT;
            S_EWAIT: begin
                if (ready_encryption)
                    state_d = (op_q == OP_LOOKUP) ? S_OUT : S_PREG;
`ifdef CDE_CTRL_TIMEOUT_EN
                else if (wait_zero) begin
                    state_d  = S_RESP;
                    status_d = ST_ERR;
                end
`endif
            end
            S_OUT:  state_d = S_RESP;
            S_PREG: state_d = S_WR;
            S_WR: begin
                state_d     = S_RESP;
                entry_cnt_d = entry_cnt_q + 1'b1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        dp_ctrl_d     = '0;
        write_add_d   = '0;
        flash_rd_en_d = 1'b0;
        flash_wr_en_d = 1'b0;

        // Selects are a function of the op and stay put for the whole sequence.
        if (state_d != S_IDLE && state_d != S_RESP) begin
            if (op_d == OP_LOOKUP) begin
                dp_ctrl_d[DP_FLASH_OR_ACC_SEL] = 1'b1;
                dp_ctrl_d[DP_BOOT_LOOD]        = 1'b1;
                dp_ctrl_d[DP_NEW_OLD_PASS_SEL] = 1'b1;
                dp_ctrl_d[DP_LOCAL_MASTER_SEL] = 1'b1;
            end else if (op_d == OP_ENROLL) begin
                dp_ctrl_d[DP_FLASH_OR_ACC_SEL] = 1'b1;
            end
        end

        case (state_d)
            S_B_RD: begin
                flash_rd_en_d = 1'b1;
                write_add_d   = idx_d;
            end
            S_B_LAT: dp_ctrl_d[DP_FLASH_OR_ACC_REG] = 1'b1;
            S_B_WR: begin
                dp_ctrl_d[DP_WRITE_EN] = 1'b1;
                write_add_d            = idx_d;
            end
            S_LAT:  dp_ctrl_d[DP_FLASH_OR_ACC_REG] = 1'b1;
            S_CAM:  dp_ctrl_d[DP_CAM_START]        = 1'b1;
            S_RD:   flash_rd_en_d                  = 1'b1;
            S_PLAT: dp_ctrl_d[DP_PASS_ENC_REG]     = 1'b1;
            S_DEC:  dp_ctrl_d[DP_START_DEC]        = 1'b1;
            S_ACC:  dp_ctrl_d[DP_FLASH_ACC_REG]    = 1'b1;
            S_KEY: begin
                dp_ctrl_d[DP_PLAIN_REG]        = 1'b1;
                dp_ctrl_d[DP_LOCAL_MASTER_REG] = 1'b1;
            end
            S_ENC:  dp_ctrl_d[DP_START_ENC]      = 1'b1;
            S_OUT:  dp_ctrl_d[DP_OUT_REG]        = 1'b1;
            S_PREG: dp_ctrl_d[DP_FLASH_PASS_REG] = 1'b1;
            S_WR: begin
                dp_ctrl_d[DP_WRITE_EN] = 1'b1;
                flash_wr_en_d          = 1'b1;
                write_add_d            = entry_cnt_q[ADDR_WIDTH-1:0];
            end
            default: ;
        endcase

        resp_valid_d  = (state_d == S_RESP);
        resp_status_d = (state_d == S_RESP) ? status_d : ST_OK;
        cmd_ready_d   = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            op_q          <= OP_BOOT;
            boot_cnt_q    <= '0;
            idx_q         <= '0;
            clamp_q       <= 1'b0;
            entry_cnt_q   <= '0;
            dp_ctrl_q     <= '0;
            write_add_q   <= '0;
            flash_rd_en_q <= 1'b0;
            flash_wr_en_q <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_status_q <= ST_OK;
            cmd_ready_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            boot_cnt_q    <= boot_cnt_d;
            idx_q         <= idx_d;
            clamp_q       <= clamp_d;
            entry_cnt_q   <= entry_cnt_d;
            dp_ctrl_q     <= dp_ctrl_d;
            write_add_q   <= write_add_d;
            flash_rd_en_q <= flash_rd_en_d;
            flash_wr_en_q <= flash_wr_en_d;
            resp_valid_q  <= resp_valid_d;
            resp_status_q <= resp_status_d;
            cmd_ready_q   <= cmd_ready_d;
        end
    end

    assign dp_ctrl         = dp_ctrl_q;
    assign write_add       = write_add_q;
    assign flash_rd_en     = flash_rd_en_q;
    assign flash_wr_en     = flash_wr_en_q;
    assign entry_cnt       = entry_cnt_q;
    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_status = resp_status_q;
endmodule

`default_nettype wire

// File: tb/tb_cde_ctrl.sv
// ============================================================================
// Module : tb_cde_ctrl
// Brief  : Scoreboard bench for cde_ctrl with pulse/address trace checks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cde_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        match = 1'b0;
    logic        dec_done = 1'b0;
    logic        ready_encryption = 1'b0;
    logic [15:0] dp_ctrl;
    logic [3:0]  write_add;
    logic        flash_rd_en;
    logic        flash_wr_en;
    logic [4:0]  entry_cnt;

    cde_ctrl_if #(.ADDR_WIDTH(4)) cif ();

    cde_ctrl #(.ADDR_WIDTH(4), .CAM_LAT(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (cif),
        .match            (match),
        .dec_done         (dec_done),
        .ready_encryption (ready_encryption),
        .dp_ctrl          (dp_ctrl),
        .write_add        (write_add),
        .flash_rd_en      (flash_rd_en),
        .flash_wr_en      (flash_wr_en),
        .entry_cnt        (entry_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { int st; int ent; int due; } exp_t;
    exp_t sb[$];
    int   ev_log[$];
    int   addr_log[$];
    int   exp_q[$];
    int   key_sel = -1;
    int   cyc = 0;
    int   resp_cnt = 0;
    int   checks = 0;
    int   failures = 0;
    bit   dec_hold = 1'b0;
    bit   enc_hold = 1'b0;
    logic [15:0] pulse_mask = 16'b0011_0110_1011_1111;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_seq(input string name, input int act[$], input int exp[$]);
        int bad = -1;
        checks++;
        for (int i = 0; i < exp.size() && i < act.size(); i++)
            if (bad < 0 && act[i] != exp[i]) bad = i;
        if (bad < 0 && act.size() != exp.size()) bad = (act.size() < exp.size()) ? act.size() : exp.size();
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s: length got %0d expected %0d, first difference at %0d (got %0d expected %0d)",
                     name, act.size(), exp.size(), bad,
                     (bad < act.size()) ? act[bad] : -1, (bad < exp.size()) ? exp[bad] : -1);
        end
    endtask

    // Monitor: trace datapath pulses and score every response.
    always @(negedge clk) begin
        if (rst) begin
            for (int b = 0; b < 16; b++)
                if (dp_ctrl[b] && pulse_mask[b]) ev_log.push_back(b);
            if (flash_rd_en) ev_log.push_back(16);
            if (flash_wr_en) ev_log.push_back(17);
            if (flash_rd_en || dp_ctrl[13] || flash_wr_en) addr_log.push_back(int'(write_add));
            if (dp_ctrl[9]) key_sel = int'({dp_ctrl[8], dp_ctrl[11]});
        end
        if (cif.resp_valid) begin
            exp_t e;
            resp_cnt++;
            if (sb.size() == 0) begin
                chk("resp_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("resp_status", int'(cif.resp_status), e.st);
                chk("resp_entry_cnt", int'(entry_cnt), e.ent);
                if (e.due >= 0) chk("resp_cycle", cyc, e.due);
            end
        end
    end

    // Decrypt core model: a spurious done in the start cycle, the real one 5 cycles later.
    initial begin : dec_model
        forever begin
            @(negedge clk);
            if (rst && dp_ctrl[1]) begin
                if (dec_hold) begin
                    while (dec_hold) @(negedge clk);
                end else begin
                    dec_done = 1'b1;
                    @(negedge clk);
                    dec_done = 1'b0;
                    repeat (4) @(negedge clk);
                end
                dec_done = 1'b1;
                @(negedge clk);
                dec_done = 1'b0;
            end
        end
    end

    initial begin : enc_model
        forever begin
            @(negedge clk);
            if (rst && dp_ctrl[2]) begin
                if (enc_hold) begin
                    while (enc_hold) @(negedge clk);
                end else begin
                    ready_encryption = 1'b1;
                    @(negedge clk);
                    ready_encryption = 1'b0;
                    repeat (4) @(negedge clk);
                end
                ready_encryption = 1'b1;
                @(negedge clk);
                ready_encryption = 1'b0;
            end
        end
    end

    // st < 0: no response expected from this command; lat < 0: response cycle not checked.
    task automatic send(input int op, input int bc, input int st, input int ent, input int lat);
        int n = 0;
        @(negedge clk);
        ev_log.delete();
        addr_log.delete();
        key_sel = -1;
        cif.cmd_valid  = 1'b1;
        cif.cmd_op     = 2'(op);
        cif.boot_count = 5'(bc);
        while (!cif.cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("accept_timeout", 0, 1);
        if (st >= 0) sb.push_back('{st, ent, (lat < 0) ? -1 : cyc + lat});
        @(negedge clk);
        cif.cmd_valid = 1'b0;
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (sb.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("response_timeout", int'(sb.size()), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin : guard
        #300000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin : stim
        int c0;
        int n;
        cif.cmd_valid  = 1'b0;
        cif.cmd_op     = 2'd0;
        cif.boot_count = 5'd0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_cmd_ready", int'(cif.cmd_ready), 1);
        chk("reset_dp_ctrl", int'(dp_ctrl), 0);
        chk("reset_resp_valid", int'(cif.resp_valid), 0);
        chk("reset_entry_cnt", int'(entry_cnt), 0);
        chk("reset_strobes", int'({flash_rd_en, flash_wr_en, write_add}), 0);

        send(0, 3, 0, 3, 10);
        drain(200);
        exp_q = {16, 5, 13, 16, 5, 13, 16, 5, 13};
        chk_seq("boot3_seq", ev_log, exp_q);
        exp_q = {0, 0, 1, 1, 2, 2};
        chk_seq("boot3_addr", addr_log, exp_q);

        match = 1'b0;
        send(1, 0, 1, 3, 5);
        drain(200);
        exp_q = {5, 0};
        chk_seq("lookup_nomatch_seq", ev_log, exp_q);

        match = 1'b1;
        send(1, 0, 0, 3, 21);
        drain(200);
        exp_q = {5, 0, 16, 7, 1, 9, 10, 2, 12};
        chk_seq("lookup_match_seq", ev_log, exp_q);
        chk("lookup_key_sel", key_sel, 3);

        send(2, 0, 3, 3, 5);
        drain(200);
        exp_q = {5, 0};
        chk_seq("enroll_dup_seq", ev_log, exp_q);

        send(3, 0, 3, 3, 1);
        drain(200);
        chk("reserved_no_dp", int'(ev_log.size()), 0);

        send(0, 0, 0, 0, 1);
        drain(200);
        send(0, 5, 0, 5, 16);
        drain(200);

        match = 1'b0;
        send(2, 0, 0, 6, 15);
        drain(200);
        exp_q = {5, 0, 4, 9, 10, 2, 3, 13, 17};
        chk_seq("enroll_seq", ev_log, exp_q);
        exp_q = {5};
        chk_seq("enroll_addr", addr_log, exp_q);
        chk("enroll_key_sel", key_sel, 0);

        // Request held high across a busy BOOT: the second op waits for IDLE.
        @(negedge clk);
        cif.cmd_valid  = 1'b1;
        cif.cmd_op     = 2'd0;
        cif.boot_count = 5'd2;
        c0 = cyc;
        sb.push_back('{0, 2, c0 + 7});
        sb.push_back('{3, 2, c0 + 9});
        @(negedge clk);
        cif.cmd_op = 2'd3;
        chk("busy_cmd_ready", int'(cif.cmd_ready), 0);
        while (cyc < c0 + 9) @(negedge clk);
        cif.cmd_valid = 1'b0;
        drain(200);

        send(0, 16, 0, 16, 49);
        drain(200);
        send(2, 0, 2, 16, 1);
        drain(200);
        chk("full_no_dp", int'(ev_log.size()) + int'(addr_log.size()), 0);
        send(0, 20, 3, 16, 49);
        drain(200);

        match    = 1'b1;
        dec_hold = 1'b1;
`ifdef CDE_CTRL_TIMEOUT_EN
        send(1, 0, 3, 16, 1031);
        drain(1200);
        dec_hold = 1'b0;
        repeat (3) @(negedge clk);
`else
        n = resp_cnt;
        send(1, 0, -1, 0, -1);
        repeat (1100) @(negedge clk);
        chk("no_watchdog_resp", resp_cnt, n);
        sb.push_back('{0, 16, -1});
        dec_hold = 1'b0;
        drain(200);
`endif

        match = 1'b0;
        send(0, 1, 0, 1, 4);
        drain(200);

        // Reset while the encrypt core is busy: no response, all outputs cleared.
        enc_hold = 1'b1;
        n = resp_cnt;
        send(2, 0, -1, 0, -1);
        c0 = 0;
        while (!dp_ctrl[2] && c0 < 100) begin
            @(negedge clk);
            c0++;
        end
        chk("enc_start_seen", int'(dp_ctrl[2]), 1);
        #2 rst = 1'b0;
        #1;
        chk("midop_rst_dp_ctrl", int'(dp_ctrl), 0);
        chk("midop_rst_strobes", int'({flash_rd_en, flash_wr_en, write_add}), 0);
        chk("midop_rst_entry_cnt", int'(entry_cnt), 0);
        chk("midop_rst_resp", int'({cif.resp_valid, cif.resp_status}), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        enc_hold = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_ready", int'(cif.cmd_ready), 1);
        chk("midop_no_resp", resp_cnt, n);

        send(2, 0, 0, 1, 15);
        drain(200);
        exp_q = {0};
        chk_seq("post_rst_enroll_addr", addr_log, exp_q);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/cde_ctrl.md
Name: cde_ctrl

Overview:
Sequencing controller for the credential datapath (cde): CAM, AES encrypt core, inverse-AES decrypt core, and their staging registers. Accepts one command at a time (BOOT, LOOKUP, ENROLL) over a valid/ready handshake. Drives all cde register enables, selects and start strobes, plus flash read/write strobes. Returns a single-cycle status response.

Parameters:
ADDR_WIDTH, 4, CAM/flash address width; capacity = 2**ADDR_WIDTH entries
CAM_LAT, 2, cycles from cam_start to a valid match/match_add

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command request
cmd_op  in  2  0=BOOT, 1=LOOKUP, 2=ENROLL, 3=reserved
cmd_ready  out  1  high only in IDLE
boot_count  in  ADDR_WIDTH+1  number of flash entries to load on BOOT
match  in  1  CAM match flag
dec_done  in  1  decrypt complete pulse
ready_encryption  in  1  encrypt complete pulse
dp_ctrl  out  16  cde control vector (bit map in package)
write_add  out  ADDR_WIDTH  CAM write / flash write address
flash_rd_en  out  1  flash read strobe; data_flash valid next cycle
flash_wr_en  out  1  flash write strobe of write_data_flash at add_flash
resp_valid  out  1  one-cycle response pulse
resp_status  out  2  0=OK, 1=NOMATCH, 2=FULL, 3=ERR
entry_cnt  out  ADDR_WIDTH+1  valid CAM entries

Behaviour:
- Reset (rst low, async): state IDLE; dp_ctrl, write_add, strobes, resp_* and entry_cnt = 0; cmd_ready = 1 on first cycle after release.
- Command accepted on cmd_valid & cmd_ready; cmd_op and boot_count captured. cmd_ready is low until the response cycle ends. Reserved op -> resp ERR next cycle.
- All dp_ctrl enables and starts are single-cycle pulses. Selects hold their value for the whole op. Outputs are registered (Moore).
- BOOT: entry_cnt cleared. Per idx 0..boot_count-1:
  - RD: flash_rd_en, boot_lood=0, write_add=idx.
  - LAT: flash_or_acc_sel=0, flash_or_acc_reg.
  - WR: write_en, write_add=idx.
  - 3 cycles/entry. entry_cnt = boot_count at end; resp OK.
  - boot_count=0 -> immediate OK.
  - boot_count > capacity -> clamp to capacity, resp ERR.
- LOOKUP:
  - LAT: flash_or_acc_sel=1, flash_or_acc_reg.
  - CAM: cam_start, then wait CAM_LAT cycles; sample match.
  - No match -> NOMATCH.
  - Match: RD (boot_lood=1, flash_rd_en) -> PLAT (pass_enc_reg) -> DEC (start_dec; wait dec_done) -> KEY (new_old_pass_sel=1, plain_reg, local_master_sel=1, local_master_reg) -> ENC (start_enc; wait ready_encryption) -> OUT (out_reg) -> resp OK.
- ENROLL:
  - entry_cnt == capacity -> FULL without touching the datapath.
  - Otherwise: account latch and CAM search as in LOOKUP. Match -> ERR (duplicate).
  - Else: ACC (flash_acc_reg) -> KEY (new_old_pass_sel=0, plain_reg, local_master_sel=0, local_master_reg) -> ENC (start_enc; wait ready_encryption) -> PREG (flash_pass_reg) -> WR (boot_lood=0, write_add=entry_cnt, flash_wr_en, write_en same cycle) -> entry_cnt+1, resp OK.
- A done pulse arriving in the same cycle as its start is ignored. Done pulses outside their wait state are ignored.
- Reset mid-op aborts with no response; entry_cnt returns to 0.

Optional Feature:
CDE_CTRL_TIMEOUT_EN:
- Defined: a 10-bit watchdog runs in the DEC and ENC wait states. If 1023 cycles pass without a done pulse, the op aborts with resp ERR and returns to IDLE; entry_cnt is unchanged.
- Undefined: no watchdog; the controller waits indefinitely.

Decomposition:
Package cde_ctrl_pkg holds:
- op encodings, status encodings, state enum
- dp_ctrl bit indices:
  - 0 cam_start, 1 start_dec, 2 start_enc, 3 flash_pass_reg, 4 flash_acc_reg
  - 5 flash_or_acc_reg, 6 flash_or_acc_sel, 7 pass_enc_reg, 8 new_old_pass_sel, 9 plain_reg
  - 10 local_master_reg, 11 local_master_sel, 12 out_reg, 13 write_en, 14 boot_lood, 15 reserved 0

Sub-module cde_ctrl_wait: a loadable down-counter used for the CAM_LAT wait and the optional watchdog.

Test Plan:
- BOOT with boot_count=3 -> flash_rd_en at write_add 0,1,2; write_en pulses exactly 3; entry_cnt=3; resp OK after 9 cycles plus response.
- LOOKUP with match=1 and dec_done/ready_encryption after 5 cycles each -> order cam_start, pass_enc_reg, start_dec, plain_reg with sel=1, start_enc, out_reg; resp OK.
- LOOKUP with match=0 -> NOMATCH; start_dec and start_enc never asserted.
- ENROLL with entry_cnt=5, no match -> flash_wr_en and write_en same cycle, write_add=5; entry_cnt=6; OK. With entry_cnt=16 -> FULL. With match=1 -> ERR.
- cmd_valid held during a busy op -> not accepted until cmd_ready; rst low during ENC -> all outputs 0 immediately, no resp_valid.
- With CDE_CTRL_TIMEOUT_EN defined and dec_done withheld -> resp ERR 1023 cycles after start_dec.
